// File: rtl/alu_pkg.sv
// Shared ALU control codes, datapath widths and the ID/EX bundle.
// Imported by the ID/EX stage and its forwarding mux.
package alu_pkg;

  localparam int XLEN    = 32;
  localparam int RA_W    = 5;
  localparam int CTRL_W  = 4;
  localparam int SHAMT_W = 5;

  typedef enum logic [CTRL_W-1:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_SLL = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_SLT = 4'b0110
  } alu_op_e;

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    rs_data;
    logic [XLEN-1:0]    rt_data;
    logic [XLEN-1:0]    imm;
    logic [SHAMT_W-1:0] shamt;
    logic [RA_W-1:0]    rs;
    logic [RA_W-1:0]    rt;
    logic [RA_W-1:0]    rd;
    logic [CTRL_W-1:0]  alu_ctrl;
    logic               alu_src;
    logic               shift;
    logic               regwrite;
    logic               mem_read;
  } id_ex_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// 3:1 operand select: EX/MEM result, MEM/WB result or register data.
// EX/MEM is the younger producer and wins; register 0 never forwards.
module operand_fwd_mux
  import alu_pkg::*;
(
  input  logic [RA_W-1:0] src,
  input  logic [XLEN-1:0] reg_data,
  input  logic            exm_regwrite,
  input  logic [RA_W-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_result,
  input  logic            mwb_regwrite,
  input  logic [RA_W-1:0] mwb_rd,
  input  logic [XLEN-1:0] mwb_result,
  output logic [XLEN-1:0] fwd_data
);

  logic exm_hit;
  logic mwb_hit;

  assign exm_hit = exm_regwrite && (exm_rd != '0) && (exm_rd == src);
  assign mwb_hit = mwb_regwrite && (mwb_rd != '0) && (mwb_rd == src);

  // Exclusive select terms so the decoder stays one-hot.
  always_comb begin
    fwd_data = reg_data;
    unique case (1'b1)
      exm_hit:              fwd_data = exm_result;
      (mwb_hit && !exm_hit): fwd_data = mwb_result;
      default:              fwd_data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detect.
// alu_* outputs drive the ALU ports directly.
module id_ex_stage
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_rs_data,
  input  logic [XLEN-1:0]    id_rt_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [SHAMT_W-1:0] id_shamt,
  input  logic [RA_W-1:0]    id_rs,
  input  logic [RA_W-1:0]    id_rt,
  input  logic [RA_W-1:0]    id_rd,
  input  logic [CTRL_W-1:0]  id_alu_ctrl,
  input  logic               id_alu_src,
  input  logic               id_shift,
  input  logic               id_regwrite,
  input  logic               id_mem_read,
  input  logic               stall,
  input  logic               flush,
  input  logic               exm_regwrite,
  input  logic [RA_W-1:0]    exm_rd,
  input  logic [XLEN-1:0]    exm_result,
  input  logic               mwb_regwrite,
  input  logic [RA_W-1:0]    mwb_rd,
  input  logic [XLEN-1:0]    mwb_result,
  output logic [XLEN-1:0]    alu_in1,
  output logic [XLEN-1:0]    alu_in2,
  output logic [CTRL_W-1:0]  alu_ctrl,
  output logic               ex_valid,
  output logic [RA_W-1:0]    ex_rd,
  output logic               ex_regwrite,
  output logic               ex_mem_read,
  output logic [XLEN-1:0]    ex_store_data,
  output logic               load_use
);

  id_ex_t          ex_d;
  id_ex_t          ex_q;
  logic [XLEN-1:0] fwd_rs;
  logic [XLEN-1:0] fwd_rt;

  operand_fwd_mux u_fwd_rs (
    .src          (ex_q.rs),
    .reg_data     (ex_q.rs_data),
    .exm_regwrite (exm_regwrite),
    .exm_rd       (exm_rd),
    .exm_result   (exm_result),
    .mwb_regwrite (mwb_regwrite),
    .mwb_rd       (mwb_rd),
    .mwb_result   (mwb_result),
    .fwd_data     (fwd_rs)
  );

  operand_fwd_mux u_fwd_rt (
    .src          (ex_q.rt),
    .reg_data     (ex_q.rt_data),
    .exm_regwrite (exm_regwrite),
    .exm_rd       (exm_rd),
    .exm_result   (exm_result),
    .mwb_regwrite (mwb_regwrite),
    .mwb_rd       (mwb_rd),
    .mwb_result   (mwb_result),
    .fwd_data     (fwd_rt)
  );

  // Next stage contents: flush beats stall; a stall refreshes operands.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (stall) begin
      ex_d.rs_data = fwd_rs;
      ex_d.rt_data = fwd_rt;
    end else begin
      ex_d.valid    = id_valid;
      ex_d.rs_data  = id_rs_data;
      ex_d.rt_data  = id_rt_data;
      ex_d.imm      = id_imm;
      ex_d.shamt    = id_shamt;
      ex_d.rs       = id_rs;
      ex_d.rt       = id_rt;
      ex_d.rd       = id_rd;
      ex_d.alu_ctrl = id_alu_ctrl;
      ex_d.alu_src  = id_alu_src;
      ex_d.shift    = id_shift;
      ex_d.regwrite = id_regwrite;
      ex_d.mem_read = id_mem_read;
    end
  end

  // Stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  // Operand select into the ALU.
  always_comb begin
    alu_in1 = ex_q.shift
            ? {{(XLEN-SHAMT_W){1'b0}}, ex_q.shamt}
            : fwd_rs;
    alu_in2 = ex_q.alu_src ? ex_q.imm : fwd_rt;
  end

  assign alu_ctrl      = ex_q.alu_ctrl;
  assign ex_valid      = ex_q.valid;
  assign ex_rd         = ex_q.rd;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_store_data = fwd_rt;

  // A load in EX whose target is read by the instruction in ID.
  always_comb begin
    load_use = id_valid && ex_q.valid && ex_q.mem_read
            && (ex_q.rd != '0)
            && ((ex_q.rd == id_rs) || (ex_q.rd == id_rt));
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage.
// Expectations are queued at drive time and popped after the edge.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
  logic [3:0]  id_alu_ctrl;
  logic        id_alu_src, id_shift, id_regwrite, id_mem_read;
  logic        stall, flush;
  logic        exm_regwrite, mwb_regwrite;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_result;
  logic [31:0] alu_in1, alu_in2, ex_store_data;
  logic [3:0]  alu_ctrl;
  logic        ex_valid, ex_regwrite, ex_mem_read, load_use;
  logic [4:0]  ex_rd;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  ctrl;
    logic        v;
    logic        rw;
    logic        mr;
    logic [4:0]  rd;
    logic [31:0] sd;
    logic        bub;
  } exp_t;

  exp_t sb[$];

  id_ex_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_rs_data    (id_rs_data),
    .id_rt_data    (id_rt_data),
    .id_imm        (id_imm),
    .id_shamt      (id_shamt),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .id_alu_ctrl   (id_alu_ctrl),
    .id_alu_src    (id_alu_src),
    .id_shift      (id_shift),
    .id_regwrite   (id_regwrite),
    .id_mem_read   (id_mem_read),
    .stall         (stall),
    .flush         (flush),
    .exm_regwrite  (exm_regwrite),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mwb_regwrite  (mwb_regwrite),
    .mwb_rd        (mwb_rd),
    .mwb_result    (mwb_result),
    .alu_in1       (alu_in1),
    .alu_in2       (alu_in2),
    .alu_ctrl      (alu_ctrl),
    .ex_valid      (ex_valid),
    .ex_rd         (ex_rd),
    .ex_regwrite   (ex_regwrite),
    .ex_mem_read   (ex_mem_read),
    .ex_store_data (ex_store_data),
    .load_use      (load_use)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(string tag, logic [31:0] in1, logic [31:0] in2,
                      logic [3:0] ctrl, logic v, logic rw, logic mr,
                      logic [4:0] rd, logic [31:0] sd, logic bub);
    exp_t e;
    e.tag = tag; e.in1 = in1; e.in2 = in2; e.ctrl = ctrl;
    e.v = v; e.rw = rw; e.mr = mr; e.rd = rd; e.sd = sd; e.bub = bub;
    sb.push_back(e);
  endtask

  task automatic tick_check();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".valid"}, ex_valid, e.v);
    chk({e.tag, ".regwr"}, ex_regwrite, e.rw);
    chk({e.tag, ".memrd"}, ex_mem_read, e.mr);
    chk({e.tag, ".ctrl"}, alu_ctrl, e.ctrl);
    chk({e.tag, ".rd"}, ex_rd, e.rd);
    if (!e.bub) begin
      chk({e.tag, ".in1"}, alu_in1, e.in1);
      chk({e.tag, ".in2"}, alu_in2, e.in2);
      chk({e.tag, ".sd"}, ex_store_data, e.sd);
    end
  endtask

  task automatic set_id(logic v, logic [31:0] rsd, logic [31:0] rtd,
                        logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                        logic [3:0] ctrl, logic rw, logic mr);
    id_valid = v; id_rs_data = rsd; id_rt_data = rtd;
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_alu_ctrl = ctrl; id_regwrite = rw; id_mem_read = mr;
    id_alu_src = 1'b0; id_shift = 1'b0;
    id_imm = 32'h0; id_shamt = 5'd0;
  endtask

  initial begin
    rst_n = 1'b0;
    set_id(1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 4'h0, 1'b0, 1'b0);
    stall = 1'b0; flush = 1'b0;
    exm_regwrite = 1'b0; exm_rd = 5'd0; exm_result = 32'h0;
    mwb_regwrite = 1'b0; mwb_rd = 5'd0; mwb_result = 32'h0;
    #12;
    chk("rst.valid", ex_valid, 1'b0);
    chk("rst.ctrl", alu_ctrl, 4'h0);
    chk("rst.in1", alu_in1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain capture
    set_id(1'b1, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 4'b0000, 1'b1, 1'b0);
    push("cap", 32'd5, 32'd7, 4'h0, 1'b1, 1'b1, 1'b0, 5'd3, 32'd7, 1'b0);
    tick_check();

    // Shift amount and immediate select
    set_id(1'b1, 32'd5, 32'd7, 5'd1, 5'd2, 5'd6, 4'b0100, 1'b1, 1'b0);
    id_shift = 1'b1; id_shamt = 5'd9;
    id_alu_src = 1'b1; id_imm = 32'hFFFF_FFF0;
    push("shimm", 32'd9, 32'hFFFF_FFF0, 4'h4, 1'b1, 1'b1, 1'b0,
         5'd6, 32'd7, 1'b0);
    tick_check();

    // Forwarding priority on rs=3
    set_id(1'b1, 32'h11, 32'd7, 5'd3, 5'd2, 5'd8, 4'b0001, 1'b1, 1'b0);
    exm_regwrite = 1'b1; exm_rd = 5'd3; exm_result = 32'hDEAD;
    mwb_regwrite = 1'b1; mwb_rd = 5'd3; mwb_result = 32'hBEEF;
    push("fwd_exm", 32'hDEAD, 32'd7, 4'h1, 1'b1, 1'b1, 1'b0,
         5'd8, 32'd7, 1'b0);
    tick_check();
    exm_regwrite = 1'b0;
    #1 chk("fwd_mwb.in1", alu_in1, 32'hBEEF);
    mwb_regwrite = 1'b0;
    #1 chk("fwd_none.in1", alu_in1, 32'h11);
    mwb_regwrite = 1'b1; mwb_rd = 5'd2;
    #1 chk("fwd_rt.in2", alu_in2, 32'hBEEF);
    chk("fwd_rt.sd", ex_store_data, 32'hBEEF);
    mwb_regwrite = 1'b0;

    // Register 0 never forwards
    @(negedge clk);
    set_id(1'b1, 32'h22, 32'h33, 5'd0, 5'd0, 5'd1, 4'b0010, 1'b1, 1'b0);
    exm_regwrite = 1'b1; exm_rd = 5'd0; exm_result = 32'hDEAD;
    push("r0", 32'h22, 32'h33, 4'h2, 1'b1, 1'b1, 1'b0,
         5'd1, 32'h33, 1'b0);
    tick_check();
    exm_regwrite = 1'b0;

    // Load-use detection and flush
    set_id(1'b1, 32'h40, 32'h44, 5'd1, 5'd2, 5'd4, 4'b0000, 1'b1, 1'b1);
    id_alu_src = 1'b1; id_imm = 32'd8;
    push("load", 32'h40, 32'd8, 4'h0, 1'b1, 1'b1, 1'b1,
         5'd4, 32'h44, 1'b0);
    tick_check();
    set_id(1'b1, 32'h1, 32'h2, 5'd4, 5'd6, 5'd7, 4'b0011, 1'b1, 1'b0);
    #1 chk("lu.rs", load_use, 1'b1);
    id_rs = 5'd5;
    #1 chk("lu.none", load_use, 1'b0);
    id_rt = 5'd4;
    #1 chk("lu.rt", load_use, 1'b1);
    id_valid = 1'b0;
    #1 chk("lu.idinv", load_use, 1'b0);
    id_valid = 1'b1;
    flush = 1'b1;
    push("lu_flush", 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0,
         5'd0, 32'h0, 1'b1);
    tick_check();
    chk("lu.after", load_use, 1'b0);
    flush = 1'b0;

    // Stall with operand refresh
    set_id(1'b1, 32'h55, 32'h66, 5'd7, 5'd8, 5'd9, 4'b0011, 1'b1, 1'b0);
    push("pre_stall", 32'h55, 32'h66, 4'h3, 1'b1, 1'b1, 1'b0,
         5'd9, 32'h66, 1'b0);
    tick_check();
    stall = 1'b1;
    exm_regwrite = 1'b1; exm_rd = 5'd7; exm_result = 32'h1234;
    set_id(1'b1, 32'h999, 32'h888, 5'd1, 5'd2, 5'd1, 4'b0010, 1'b0, 1'b1);
    #1 chk("stall.fwd", alu_in1, 32'h1234);
    push("stall1", 32'h1234, 32'h66, 4'h3, 1'b1, 1'b1, 1'b0,
         5'd9, 32'h66, 1'b0);
    tick_check();
    exm_regwrite = 1'b0;
    #1 chk("stall.keep", alu_in1, 32'h1234);
    push("stall2", 32'h1234, 32'h66, 4'h3, 1'b1, 1'b1, 1'b0,
         5'd9, 32'h66, 1'b0);
    tick_check();
    flush = 1'b1;
    push("flush_stall", 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0,
         5'd0, 32'h0, 1'b1);
    tick_check();
    stall = 1'b0; flush = 1'b0;

    // Random captures, forwarding disabled
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b, im, e1, e2;
      logic [4:0]  sh, rd;
      logic [3:0]  c;
      logic        s, src;
      a = $urandom; b = $urandom; im = $urandom;
      sh = 5'($urandom); rd = 5'($urandom);
      c = 4'($urandom_range(0, 6));
      s = 1'($urandom); src = 1'($urandom);
      set_id(1'b1, a, b, 5'd10, 5'd11, rd, c, 1'b1, 1'b0);
      id_shift = s; id_shamt = sh; id_alu_src = src; id_imm = im;
      e1 = s ? {27'b0, sh} : a;
      e2 = src ? im : b;
      push($sformatf("rnd%0d", i), e1, e2, c, 1'b1, 1'b1, 1'b0,
           rd, b, 1'b0);
      tick_check();
    end

    // Asynchronous reset mid-stream
    set_id(1'b1, 32'h77, 32'h78, 5'd1, 5'd2, 5'd5, 4'b0110, 1'b1, 1'b0);
    push("pre_rst", 32'h77, 32'h78, 4'h6, 1'b1, 1'b1, 1'b0,
         5'd5, 32'h78, 1'b0);
    tick_check();
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", ex_valid, 1'b0);
    chk("arst.ctrl", alu_ctrl, 4'h0);
    chk("arst.regwr", ex_regwrite, 1'b0);
    chk("arst.in1", alu_in1, 32'h0);
    chk("sb_drain", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
